// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for cycle_sequencer.
// Opcodes match the RV32I base decoder.
package seq_pkg;

  localparam int CNT_W = 8;

  // FAULT is held by the sticky fault flag; the 3-bit code
  // has room for only eight values.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM      = 3'd4,
    S_WAIT_MUL = 3'd5,
    S_WAIT_IO  = 3'd6,
    S_WB       = 3'd7
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Load value so that done rises after exactly n cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// seq_wait_counter: loadable down-counter with a done flag,
// shared by the RAM read hold and the multiply timeout.
module seq_wait_counter
  import seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multicycle control FSM for the core.
// SEQ_PERF_CNT_EN adds cycleCnt/instretCnt outputs.
module cycle_sequencer
  import seq_pkg::*;
#(
  parameter int RAM_RD_LAT  = 1,
  parameter int MUL_TIMEOUT = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic [6:0]  opcode,
  input  logic        regw,
  input  logic        ramR,
  input  logic        ramW,
  input  logic        mulEn,
  input  logic        inputbool,
  input  logic        outputbool,
  input  logic        illegal,
  input  logic        mulDone,
  input  logic        adcValid,
  input  logic        dacReady,
  output logic        irEn,
  output logic        pcEn,
  output logic        regwEn,
  output logic        ramRdEn,
  output logic        ramWrEn,
  output logic        mulStart,
  output logic        adcAck,
  output logic        dacValid,
  output logic        fault,
  output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycleCnt,
  output logic [31:0] instretCnt
`endif
);

  localparam logic [CNT_W-1:0] RD_LOAD  = cnt_load(RAM_RD_LAT);
  localparam logic [CNT_W-1:0] MUL_LOAD = cnt_load(MUL_TIMEOUT);

  state_e           state_q, state_d;
  logic             fault_q, fault_d;
  logic             cnt_ld, cnt_dec, cnt_done;
  logic [CNT_W-1:0] cnt_val, cnt;

  // Opcode is decoded upstream; kept on the port for debug.
  logic unused_opcode;
  assign unused_opcode = ^opcode;

  seq_wait_counter u_cnt (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (cnt_ld),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .cnt_o  (cnt),
    .done_o (cnt_done)
  );

  // State and sticky fault registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Next state and strobes; a set fault freezes everything.
  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    irEn     = 1'b0;
    pcEn     = 1'b0;
    regwEn   = 1'b0;
    ramRdEn  = 1'b0;
    ramWrEn  = 1'b0;
    mulStart = 1'b0;
    adcAck   = 1'b0;
    dacValid = 1'b0;
    cnt_ld   = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    if (!fault_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (!halt) state_d = S_FETCH;
        end
        S_FETCH: begin
          irEn    = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (illegal) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (mulEn) begin
            mulStart = 1'b1;
            cnt_ld   = 1'b1;
            cnt_val  = MUL_LOAD;
            state_d  = S_WAIT_MUL;
          end else if (ramR || ramW) begin
            cnt_ld  = 1'b1;
            cnt_val = RD_LOAD;
            state_d = S_MEM;
          end else if (inputbool || outputbool) begin
            state_d = S_WAIT_IO;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          if (ramW) begin
            ramWrEn = 1'b1;
            pcEn    = 1'b1;
            state_d = S_FETCH;
          end else begin
            ramRdEn = ramR && (cnt == RD_LOAD);
            if (cnt_done) state_d = S_WB;
            else          cnt_dec = 1'b1;
          end
        end
        S_WAIT_MUL: begin
          if (mulDone) begin
            state_d = S_WB;
          end else if (cnt_done) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        S_WAIT_IO: begin
          if (inputbool) begin
            if (adcValid) begin
              adcAck  = 1'b1;
              state_d = S_WB;
            end
          end else begin
            dacValid = 1'b1;
            if (dacReady) begin
              pcEn    = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_WB: begin
          regwEn  = regw;
          pcEn    = 1'b1;
          state_d = halt ? S_IDLE : S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign fault = fault_q;
  assign state = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  // Busy-cycle and retired-instruction counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_IDLE && !fault_q) cyc_q <= cyc_q + 1'b1;
      if (pcEn) ret_q <= ret_q + 1'b1;
    end
  end

  assign cycleCnt   = cyc_q;
  assign instretCnt = ret_q;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: random instruction streams checked
// cycle by cycle against a phase-timeline reference model.
module tb_cycle_sequencer;

  localparam int LAT = 3;
  localparam int TMO = 8;

  localparam logic [8:0] E_IR = 9'h001;
  localparam logic [8:0] E_PC = 9'h002;
  localparam logic [8:0] E_RW = 9'h004;
  localparam logic [8:0] E_RR = 9'h008;
  localparam logic [8:0] E_WR = 9'h010;
  localparam logic [8:0] E_MS = 9'h020;
  localparam logic [8:0] E_AA = 9'h040;
  localparam logic [8:0] E_DV = 9'h080;
  localparam logic [8:0] E_FT = 9'h100;

  logic       clock = 1'b0;
  logic       reset, halt;
  logic [6:0] opcode;
  logic       regw, ramR, ramW, mulEn;
  logic       inputbool, outputbool, illegal;
  logic       mulDone, adcValid, dacReady;
  logic       irEn, pcEn, regwEn, ramRdEn, ramWrEn;
  logic       mulStart, adcAck, dacValid, fault;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycleCnt, instretCnt;
`endif

  cycle_sequencer #(
    .RAM_RD_LAT  (LAT),
    .MUL_TIMEOUT (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .halt       (halt),
    .opcode     (opcode),
    .regw       (regw),
    .ramR       (ramR),
    .ramW       (ramW),
    .mulEn      (mulEn),
    .inputbool  (inputbool),
    .outputbool (outputbool),
    .illegal    (illegal),
    .mulDone    (mulDone),
    .adcValid   (adcValid),
    .dacReady   (dacReady),
    .irEn       (irEn),
    .pcEn       (pcEn),
    .regwEn     (regwEn),
    .ramRdEn    (ramRdEn),
    .ramWrEn    (ramWrEn),
    .mulStart   (mulStart),
    .adcAck     (adcAck),
    .dacValid   (dacValid),
    .fault      (fault),
    .state      (state)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycleCnt   (cycleCnt),
    .instretCnt (instretCnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] op;
    logic rw, rr, ww, me, ib, ob, il;
    logic rst, hl, md, av, dr;
    logic [8:0] exp;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  logic force_halt = 1'b0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic hx();
    return force_halt | rb();
  endfunction

  task automatic push(input logic [8:0] e, input logic hl,
                      input logic md, input logic av,
                      input logic dr, input logic rs);
    cyc_t c;
    c     = cur;
    c.exp = e;
    c.hl  = hl;
    c.md  = md;
    c.av  = av;
    c.dr  = dr;
    c.rst = rs;
    q.push_back(c);
  endtask

  task automatic push_r(input logic [8:0] e);
    push(e, hx(), rb(), rb(), rb(), 1'b0);
  endtask

  // Writeback, then optional IDLE stay of hn halted cycles.
  task automatic wb(input logic rw, input int hn);
    push(rw ? (E_PC | E_RW) : E_PC, hn >= 0,
         rb(), rb(), rb(), 1'b0);
    if (hn >= 0) begin
      for (int i = 0; i < hn; i++)
        push(9'h0, 1'b1, rb(), rb(), rb(), 1'b0);
      push(9'h0, 1'b0, rb(), rb(), rb(), 1'b0);
    end
  endtask

  // Fault is sticky until reset, then one IDLE cycle.
  task automatic fault_tail();
    for (int i = 0; i < 3; i++)
      push(E_FT, rb(), rb(), rb(), rb(), 1'b0);
    push(E_FT, rb(), rb(), rb(), rb(), 1'b1);
    push(9'h0, 1'b0, rb(), rb(), rb(), 1'b0);
  endtask

  // kind: 0 alu 1 load 2 store 3 mul 4 adc 5 dac
  //       6 illegal 7 mul timeout
  task automatic gen(input int kind, input int w, input int hn,
                     input int cut, input logic rw);
    cur    = '{default: '0};
    cur.rw = rw;
    cur.il = (kind == 6);
    case (kind)
      0: cur.op = 7'b0110011;
      1: begin cur.op = 7'b0000011; cur.rr = 1'b1; end
      2: begin cur.op = 7'b0100011; cur.ww = 1'b1; end
      3, 7: begin cur.op = 7'b0110011; cur.me = 1'b1; end
      4: begin cur.op = 7'b0001011; cur.ib = 1'b1; end
      5: begin cur.op = 7'b0101011; cur.ob = 1'b1; end
      default: cur.op = 7'b1111111;
    endcase
    push_r(E_IR);
    push_r(9'h0);
    if (kind == 6) begin
      fault_tail();
    end else begin
      push_r((kind == 3 || kind == 7) ? E_MS : 9'h0);
      case (kind)
        1: begin
          for (int i = 0; i < LAT; i++)
            push_r(i == 0 ? E_RR : 9'h0);
          wb(rw, hn);
        end
        2: push_r(E_WR | E_PC);
        3: begin
          for (int i = 0; i < w; i++)
            push(9'h0, hx(), 1'b0, rb(), rb(), 1'b0);
          push(9'h0, hx(), 1'b1, rb(), rb(), 1'b0);
          wb(rw, hn);
        end
        4: begin
          for (int i = 0; i < w; i++)
            push(9'h0, hx(), rb(), 1'b0, rb(), 1'b0);
          push(E_AA, hx(), rb(), 1'b1, rb(), 1'b0);
          wb(rw, hn);
        end
        5: begin
          for (int i = 0; i < w; i++)
            push(E_DV, hx(), rb(), rb(), 1'b0, 1'b0);
          push(E_DV | E_PC, hx(), rb(), rb(), 1'b1, 1'b0);
        end
        7: begin
          for (int i = 0; i < TMO; i++)
            push(9'h0, hx(), 1'b0, rb(), rb(), 1'b0);
          fault_tail();
        end
        default: wb(rw, hn);
      endcase
    end
    if (cut > 0 && cut < q.size()) begin
      while (q.size() > cut + 1) void'(q.pop_back());
      q[cut].rst = 1'b1;
      push(9'h0, 1'b0, rb(), rb(), rb(), 1'b0);
    end
  endtask

  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clock);
      #1;
      reset      = c.rst;
      halt       = c.hl;
      opcode     = c.op;
      regw       = c.rw;
      ramR       = c.rr;
      ramW       = c.ww;
      mulEn      = c.me;
      inputbool  = c.ib;
      outputbool = c.ob;
      illegal    = c.il;
      mulDone    = c.md;
      adcValid   = c.av;
      dacReady   = c.dr;
      #3;
      check_eq($sformatf("out@cyc%0d", ncyc),
               {23'h0, fault, dacValid, adcAck, mulStart,
                ramWrEn, ramRdEn, regwEn, pcEn, irEn},
               {23'h0, c.exp});
      ncyc++;
    end
  endtask

  initial begin
    int k, kind, w, hn, cut;
    reset = 1'b1; halt = 1'b1; opcode = '0;
    regw = 1'b0; ramR = 1'b0; ramW = 1'b0; mulEn = 1'b0;
    inputbool = 1'b0; outputbool = 1'b0; illegal = 1'b0;
    mulDone = 1'b0; adcValid = 1'b0; dacReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_out",
             {23'h0, fault, dacValid, adcAck, mulStart,
              ramWrEn, ramRdEn, regwEn, pcEn, irEn}, 32'h0);
    check_eq("rst_state", {29'h0, state}, 32'h0);

    cur = '{default: '0};
    push(9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run();

    gen(0, 0, -1, -1, 1'b1);       run();
    gen(1, 0, -1, -1, 1'b1);       run();
    gen(3, 4, -1, -1, 1'b1);       run();
    gen(7, 0, -1, -1, 1'b0);       run();
    gen(5, 3, -1, -1, 1'b1);       run();
    force_halt = 1'b1;
    gen(4, 2, 2, -1, 1'b1);        run();
    force_halt = 1'b0;
    gen(1, 0, -1, 4, 1'b1);        run();
    gen(3, TMO - 1, -1, -1, 1'b1); run();
    gen(2, 0, -1, -1, 1'b1);       run();
    gen(6, 0, -1, -1, 1'b0);       run();

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 99);
      kind = (k < 18) ? 0 : (k < 32) ? 1 : (k < 44) ? 2 :
             (k < 58) ? 3 : (k < 72) ? 4 : (k < 88) ? 5 :
             (k < 94) ? 6 : 7;
      if (kind == 3)
        w = ($urandom_range(0, 3) == 0) ? TMO - 1
            : $urandom_range(0, TMO - 1);
      else
        w = $urandom_range(0, 4);
      hn  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : -1;
      gen(kind, w, hn, cut, rb());
      run();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
